bq_multi: RTL and testbench

Parametrised successor to `bqmain`. It is a multi-channel, time-multiplexed Direct-Form-I biquad IIR filter with per-channel coefficient and control registers on the Wishbone slave port. One shared multiplier-accumulator serves all channels, one product per cycle. Samples enter via a valid/ready handshake tagged with a channel number; results leave as a tagged one-cycle pulse. It sits inside `user_project_wrapper`, fed from the logic analyser or IO pads.

---
 rtl/bq_multi.sv | 231 +++++++++++++++++++++++
 tb/tb_bq_multi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bq_multi.sv
// Multi-channel time-multiplexed Direct-Form-I biquad with a Wishbone register file.
// One shared multiplier-accumulator walks the five taps of one sample at a time.
module bq_multi #(
   parameter int DW   = 12,
   parameter int CW   = 16,
   parameter int FRAC = 14,
   parameter int NCH  = 4,
   parameter int CHW  = 3
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [31:0]   wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   input  logic [DW-1:0] x_i,
   input  logic [CHW-1:0] x_ch_i,
   input  logic          x_valid_i,
   output logic          x_ready_o,
   output logic [DW-1:0] y_o,
   output logic [CHW-1:0] y_ch_o,
   output logic          y_valid_o
);

   localparam int ACCW  = DW + CW + 3;
   localparam int PW    = DW + CW;
   localparam int NSLOT = 1 << CHW;
   localparam logic signed [ACCW-1:0] RHALF = ACCW'(1) << (FRAC - 1);
   localparam logic signed [ACCW-1:0] YMAX  = ACCW'((1 << (DW - 1)) - 1);
   localparam logic signed [ACCW-1:0] YMIN  = ~YMAX;

   typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, DONE} state_t;

   // Per-channel register file and filter history; slots at or above NCH are never written.
   logic signed [CW-1:0] coef [NSLOT][5];
   logic                 en_r  [NSLOT];
   logic                 sat_r [NSLOT];
   logic signed [DW-1:0] hx1 [NSLOT];
   logic signed [DW-1:0] hx2 [NSLOT];
   logic signed [DW-1:0] hy1 [NSLOT];
   logic signed [DW-1:0] hy2 [NSLOT];

   state_t               state;
   logic [CHW-1:0]       w_ch;
   logic                 w_ok;
   logic                 w_en;
   logic signed [CW-1:0] w_coef [5];
   logic signed [DW-1:0] w_x;
   logic signed [DW-1:0] w_x1;
   logic signed [DW-1:0] w_x2;
   logic signed [DW-1:0] w_y1;
   logic signed [DW-1:0] w_y2;
   logic signed [ACCW-1:0] acc;

   logic signed [CW-1:0]   mac_coef;
   logic signed [DW-1:0]   mac_opnd;
   logic                   mac_sub;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] acc_next;
   logic signed [ACCW-1:0] rnd;
   logic signed [ACCW-1:0] shf;
   logic signed [DW-1:0]   y_sat;
   logic signed [DW-1:0]   y_new;
   logic                   clip;
   logic                   commit;
   logic                   sat_hit;

   logic                 wb_req;
   logic                 wb_ch_ok;
   logic [CHW-1:0]       wb_ch;
   logic [2:0]           wb_word;
   logic [31:0]          rd_data;
   logic                 unused_bits;

   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:CW]};

   assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wb_ch    = wb_adr_i[5 +: CHW];
   assign wb_word  = wb_adr_i[4:2];
   assign wb_ch_ok = int'(wb_adr_i[7:5]) < NCH;

   assign x_ready_o = (state == IDLE) & ~wb_rst_i;

   always_comb begin
      rd_data = '0;
      if (wb_ch_ok) begin
         for (int k = 0; k < 5; k++) begin
            if (wb_word == 3'(k)) rd_data = 32'(coef[wb_ch][k]);
         end
         if (wb_word == 3'd5) rd_data = {31'd0, en_r[wb_ch]};
         if (wb_word == 3'd6) rd_data = {31'd0, sat_r[wb_ch]};
      end
   end

   // Tap selection: feed-forward taps add, feedback taps subtract.
   always_comb begin
      mac_coef = '0;
      mac_opnd = '0;
      mac_sub  = 1'b0;
      case (state)
         MAC0: begin mac_coef = w_coef[0]; mac_opnd = w_x;  end
         MAC1: begin mac_coef = w_coef[1]; mac_opnd = w_x1; end
         MAC2: begin mac_coef = w_coef[2]; mac_opnd = w_x2; end
         MAC3: begin mac_coef = w_coef[3]; mac_opnd = w_y1; mac_sub = 1'b1; end
         MAC4: begin mac_coef = w_coef[4]; mac_opnd = w_y2; mac_sub = 1'b1; end
         default: ;
      endcase
   end

   assign prod     = PW'(mac_opnd) * PW'(mac_coef);
   assign acc_next = mac_sub ? acc - ACCW'(prod) : acc + ACCW'(prod);
   assign rnd      = acc + RHALF;
   assign shf      = rnd >>> FRAC;

   always_comb begin
      clip  = 1'b0;
      y_sat = shf[DW-1:0];
      if (shf > YMAX) begin
         y_sat = YMAX[DW-1:0];
         clip  = 1'b1;
      end else if (shf < YMIN) begin
         y_sat = YMIN[DW-1:0];
         clip  = 1'b1;
      end
   end

   assign y_new   = w_en ? y_sat : w_x;
   assign commit  = (state == DONE) & w_ok;
   assign sat_hit = commit & w_en & clip;

   // Register file: statement order gives CLR priority over the history shift
   // and a saturation event priority over write-1-to-clear.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         for (int c = 0; c < NSLOT; c++) begin
            for (int k = 0; k < 5; k++) coef[c][k] <= '0;
            en_r[c]  <= 1'b0;
            sat_r[c] <= 1'b0;
            hx1[c]   <= '0;
            hx2[c]   <= '0;
            hy1[c]   <= '0;
            hy2[c]   <= '0;
         end
      end else begin
         wb_ack_o <= wb_req;
         wb_dat_o <= wb_req ? rd_data : '0;
         if (commit) begin
            hx2[w_ch] <= hx1[w_ch];
            hx1[w_ch] <= w_x;
            hy2[w_ch] <= hy1[w_ch];
            hy1[w_ch] <= y_new;
         end
         if (wb_req && wb_we_i && wb_ch_ok) begin
            for (int k = 0; k < 5; k++) begin
               if (wb_word == 3'(k)) coef[wb_ch][k] <= wb_dat_i[CW-1:0];
            end
            if (wb_word == 3'd5) begin
               en_r[wb_ch] <= wb_dat_i[0];
               if (wb_dat_i[1]) begin
                  hx1[wb_ch] <= '0;
                  hx2[wb_ch] <= '0;
                  hy1[wb_ch] <= '0;
                  hy2[wb_ch] <= '0;
               end
            end
            if (wb_word == 3'd6 && wb_dat_i[0]) sat_r[wb_ch] <= 1'b0;
         end
         if (sat_hit) sat_r[w_ch] <= 1'b1;
      end
   end

   // Sequencer: snapshot everything the sample needs at capture, then one tap per cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         acc       <= '0;
         y_o       <= '0;
         y_ch_o    <= '0;
         y_valid_o <= 1'b0;
         w_ch      <= '0;
         w_ok      <= 1'b0;
         w_en      <= 1'b0;
         w_x       <= '0;
         w_x1      <= '0;
         w_x2      <= '0;
         w_y1      <= '0;
         w_y2      <= '0;
         for (int k = 0; k < 5; k++) w_coef[k] <= '0;
      end else begin
         y_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (x_valid_i) begin
                  w_x  <= x_i;
                  w_ch <= x_ch_i;
                  w_ok <= int'(x_ch_i) < NCH;
                  w_en <= en_r[x_ch_i];
                  w_x1 <= hx1[x_ch_i];
                  w_x2 <= hx2[x_ch_i];
                  w_y1 <= hy1[x_ch_i];
                  w_y2 <= hy2[x_ch_i];
                  for (int k = 0; k < 5; k++) w_coef[k] <= coef[x_ch_i][k];
                  acc   <= '0;
                  state <= MAC0;
               end
            end
            MAC0: begin acc <= acc_next; state <= MAC1; end
            MAC1: begin acc <= acc_next; state <= MAC2; end
            MAC2: begin acc <= acc_next; state <= MAC3; end
            MAC3: begin acc <= acc_next; state <= MAC4; end
            MAC4: begin acc <= acc_next; state <= DONE; end
            DONE: begin
               if (w_ok) begin
                  y_o       <= y_new;
                  y_ch_o    <= w_ch;
                  y_valid_o <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bq_multi.sv
// Self-checking bench for bq_multi: directed corner cases plus randomized traffic
// compared against an arithmetic per-channel biquad model.
module tb_bq_multi;

   localparam int DW    = 12;
   localparam int CW    = 16;
   localparam int FRAC  = 14;
   localparam int NCH   = 4;
   localparam int CHW   = 3;
   localparam int YMAXI = 2047;
   localparam int YMINI = -2048;

   logic           clk = 1'b0;
   logic           wb_rst = 1'b1;
   logic           wb_cyc = 1'b0;
   logic           wb_stb = 1'b0;
   logic           wb_we = 1'b0;
   logic [31:0]    wb_adr = '0;
   logic [31:0]    wb_dat = '0;
   logic [3:0]     wb_sel = 4'hF;
   logic [31:0]    wb_dat_o;
   logic           wb_ack_o;
   logic [DW-1:0]  x_i = '0;
   logic [CHW-1:0] x_ch = '0;
   logic           x_valid = 1'b0;
   logic           x_ready_o;
   logic [DW-1:0]  y_o;
   logic [CHW-1:0] y_ch_o;
   logic           y_valid_o;

   int tests = 0;
   int fails = 0;

   int m_coef [8][5];
   bit m_en  [8];
   bit m_sat [8];
   int m_x1 [8];
   int m_x2 [8];
   int m_y1 [8];
   int m_y2 [8];

   always #5 clk = ~clk;

   bq_multi #(.DW(DW), .CW(CW), .FRAC(FRAC), .NCH(NCH), .CHW(CHW)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
      .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .x_i(x_i), .x_ch_i(x_ch), .x_valid_i(x_valid), .x_ready_o(x_ready_o),
      .y_o(y_o), .y_ch_o(y_ch_o), .y_valid_o(y_valid_o)
   );

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   function automatic int sext16(input int v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   function automatic logic [31:0] addrOf(input int ch, input int w);
      return 32'((ch << 5) | (w << 2));
   endfunction

   function automatic void modelReset();
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 5; k++) m_coef[c][k] = 0;
         m_en[c] = 0; m_sat[c] = 0;
         m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
      end
   endfunction

   function automatic void modelClear(input int ch);
      m_x1[ch] = 0; m_x2[ch] = 0; m_y1[ch] = 0; m_y2[ch] = 0;
   endfunction

   // Reference: the difference equation in wide integer arithmetic, round half up, clip.
   function automatic int modelStep(input int ch, input int x);
      longint acc;
      int     y;
      if (m_en[ch]) begin
         acc = longint'(m_coef[ch][0]) * x + longint'(m_coef[ch][1]) * m_x1[ch]
             + longint'(m_coef[ch][2]) * m_x2[ch] - longint'(m_coef[ch][3]) * m_y1[ch]
             - longint'(m_coef[ch][4]) * m_y2[ch];
         acc = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
         if (acc > YMAXI) begin y = YMAXI; m_sat[ch] = 1; end
         else if (acc < YMINI) begin y = YMINI; m_sat[ch] = 1; end
         else y = int'(acc);
      end else begin
         y = x;
      end
      m_x2[ch] = m_x1[ch]; m_x1[ch] = x;
      m_y2[ch] = m_y1[ch]; m_y1[ch] = y;
      return y;
   endfunction

   task automatic wbAccess(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           output logic [31:0] rd);
      int n;
      rd = '0;
      wb_adr = adr; wb_dat = dat; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 8);
      if (!wb_ack_o) checkOutput("wb_ack_timeout", 0, 1);
      else begin
         checkOutput("wb_ack_latency", n, 1);
         rd = wb_dat_o;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      checkOutput("wb_ack_pulse", wb_ack_o, 0);
   endtask

   task automatic readCheck(input string tag, input int ch, input int w, input logic [31:0] exp);
      logic [31:0] rd;
      wbAccess(addrOf(ch, w), 32'd0, 1'b0, rd);
      checkOutput(tag, rd, exp);
   endtask

   task automatic setCoef(input int ch, input int k, input int val);
      logic [31:0] rd;
      wbAccess(addrOf(ch, k), 32'(val), 1'b1, rd);
      if (ch < NCH) m_coef[ch][k] = sext16(val);
   endtask

   task automatic setCtrl(input int ch, input bit en, input bit clr);
      logic [31:0] rd;
      wbAccess(addrOf(ch, 5), {30'd0, clr, en}, 1'b1, rd);
      if (ch < NCH) begin
         m_en[ch] = en;
         if (clr) modelClear(ch);
      end
   endtask

   task automatic clearSat(input int ch);
      logic [31:0] rd;
      wbAccess(addrOf(ch, 6), 32'd1, 1'b1, rd);
      if (ch < NCH) m_sat[ch] = 0;
   endtask

   // Push one sample through and check result, tag, latency and ready timing.
   task automatic applyStimulus(input int ch, input int x, output int yv);
      int yexp, n, pulses, lat, ych;
      logic rdy5, rdy6;
      yv = 0; ych = 0; yexp = 0; lat = 0; pulses = 0; rdy5 = 1'b1; rdy6 = 1'b0;
      if (ch < NCH) yexp = modelStep(ch, x);
      n = 0;
      while (!x_ready_o && n < 20) begin @(posedge clk); #1; n++; end
      checkOutput("ready_before_send", x_ready_o, 1);
      x_i = x[DW-1:0]; x_ch = ch[CHW-1:0]; x_valid = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0;
      checkOutput("handshake_taken", x_ready_o, 0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 5) rdy5 = x_ready_o;
         if (k == 6) rdy6 = x_ready_o;
         if (y_valid_o) begin
            pulses++;
            if (pulses == 1) begin
               lat = k;
               yv  = int'($signed(y_o));
               ych = int'(y_ch_o);
            end
         end
      end
      checkOutput("ready_busy_at_done", rdy5, 0);
      checkOutput("ready_after_done", rdy6, 1);
      if (ch < NCH) begin
         checkOutput("pulse_count", pulses, 1);
         checkOutput("latency", lat, 6);
         checkOutput($sformatf("y_ch%0d", ch), yv, yexp);
         checkOutput("y_tag", ych, ch);
      end else begin
         checkOutput("invalid_no_pulse", pulses, 0);
      end
   endtask

   task automatic waitCaptureThenEdges(input int edges);
      int n;
      n = 0;
      while (x_ready_o && n < 30) begin @(posedge clk); #1; n++; end
      repeat (edges) begin @(posedge clk); #1; end
   endtask

   initial begin
      int y, pulses, ch, act;
      logic [31:0] rd;

      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready_low", x_ready_o, 0);
      checkOutput("reset_y", y_o, 0);
      checkOutput("reset_ych", y_ch_o, 0);
      checkOutput("reset_yvalid", y_valid_o, 0);
      checkOutput("reset_ack", wb_ack_o, 0);
      checkOutput("reset_dat", wb_dat_o, 0);
      wb_rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", x_ready_o, 1);

      for (int c = 0; c < 8; c++)
         for (int w = 0; w < 8; w++) readCheck("reset_reg", c, w, 32'd0);
      setCoef(0, 0, 'h8000);
      readCheck("b0_sign_ext", 0, 0, 32'hFFFF8000);
      setCoef(0, 0, 0);
      setCoef(5, 0, 'h1234);
      readCheck("unmapped_channel", 5, 0, 32'd0);
      wbAccess(addrOf(0, 7), 32'hFFFF, 1'b1, rd);
      readCheck("word7_zero", 0, 7, 32'd0);

      applyStimulus(0, 'h123, y);
      checkOutput("bypass_value", y, 'h123);

      setCoef(1, 0, 'h4000);
      setCoef(1, 1, 'h2000);
      setCtrl(1, 1, 0);
      readCheck("ctrl_readback", 1, 5, 32'd1);
      applyStimulus(1, 100, y); checkOutput("fir_0", y, 100);
      applyStimulus(1, 0, y);   checkOutput("fir_1", y, 50);
      applyStimulus(1, 0, y);   checkOutput("fir_2", y, 0);

      setCoef(2, 0, 'h4000);
      setCoef(2, 3, 'hE000);
      setCtrl(2, 1, 0);
      applyStimulus(2, 1024, y); checkOutput("iir_0", y, 1024);
      applyStimulus(2, 0, y);    checkOutput("iir_1", y, 512);
      applyStimulus(2, 0, y);    checkOutput("iir_2", y, 256);
      applyStimulus(2, 0, y);    checkOutput("iir_3", y, 128);
      setCtrl(2, 1, 1);
      readCheck("clr_reads_zero", 2, 5, 32'd1);
      applyStimulus(2, 0, y);    checkOutput("iir_after_clr", y, 0);

      setCoef(3, 0, 'h7FFF);
      setCtrl(3, 1, 0);
      applyStimulus(3, 2047, y);  checkOutput("sat_pos", y, 2047);
      applyStimulus(3, -2048, y); checkOutput("sat_neg", y, -2048);
      readCheck("sat_set", 3, 6, 32'd1);
      clearSat(3);
      readCheck("sat_cleared", 3, 6, 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i % 2) ? 3 : 0, int'($urandom_range(0, 400)) - 200, y);
      end
      readCheck("ch0_sat_isolated", 0, 6, 32'd0);

      // Sample arriving at the DONE edge with a simultaneous CLR of the same channel.
      applyStimulus(1, 0, y);
      fork
         applyStimulus(1, 100, y);
         begin waitCaptureThenEdges(5); setCtrl(1, 1, 1); end
      join
      checkOutput("clr_at_done_output", y, 100);
      applyStimulus(1, 0, y);
      checkOutput("clr_at_done_history", y, 0);

      // Coefficient rewritten mid-computation only affects later samples.
      fork
         applyStimulus(1, 200, y);
         begin waitCaptureThenEdges(1); setCoef(1, 0, 'h2000); end
      join
      checkOutput("coef_snapshot", y, 200);
      applyStimulus(1, 0, y);

      applyStimulus(3, 2047, y);
      applyStimulus(7, 2047, y);
      applyStimulus(4, -100, y);
      readCheck("sat_kept_after_invalid", 3, 6, 32'd1);
      applyStimulus(3, 10, y);

      // Reset while the sequencer is in MAC2.
      x_i = 12'd100; x_ch = 3'd1; x_valid = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wb_rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_ready_low", x_ready_o, 0);
      checkOutput("abort_no_valid", y_valid_o, 0);
      wb_rst = 1'b0;
      modelReset();
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (y_valid_o) pulses++;
      end
      checkOutput("abort_no_pulse", pulses, 0);
      checkOutput("abort_ready_back", x_ready_o, 1);
      readCheck("abort_b0_zero", 1, 0, 32'd0);
      readCheck("abort_ctrl_zero", 1, 5, 32'd0);
      readCheck("abort_sat_zero", 3, 6, 32'd0);
      applyStimulus(1, 77, y);
      checkOutput("abort_bypass", y, 77);

      for (int i = 0; i < 220; i++) begin
         act = int'($urandom_range(0, 11));
         ch  = int'($urandom_range(0, 7));
         case (act)
            0, 1: setCoef(ch, int'($urandom_range(0, 4)), int'($urandom_range(0, 'h6000)) - 'h3000);
            2:    setCtrl(ch, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            3:    readCheck("rand_sat", ch, 6, (ch < NCH) ? 32'(m_sat[ch]) : 32'd0);
            4:    clearSat(ch);
            default: applyStimulus(ch, int'($urandom_range(0, 4095)) - 2048, y);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
